// File: rtl/ahb_req_pipeline_slave.sv
// AHB-Lite slave front end for the AHB2APB bridge.
// Captures pipelined AHB address and data phases. Decodes each address to one
// of NUM_SEL APB selects. Queues mapped requests in a request FIFO for the
// APB-side engine. Writes are posted. Reads hold the AHB data phase until
// rsp_valid returns the data. Unmapped addresses get a two-cycle ERROR response.
module ahb_req_pipeline_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_SEL     = 3,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned REGION_LOG2 = 10
) (
    input  logic                        Hclk,
    input  logic                        Hresetn,
    input  logic                        Hwrite,
    input  logic                        Hreadyin,
    input  logic [1:0]                  Htrans,
    input  logic [31:0]                 Haddr,
    input  logic [DATA_W-1:0]           Hwdata,
    output logic                        Hreadyout,
    output logic                        Hresp,
    output logic [DATA_W-1:0]           Hrdata,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [31:0]                 req_addr,
    output logic [DATA_W-1:0]           req_wdata,
    output logic                        req_write,
    output logic [NUM_SEL-1:0]          req_sel,
    input  logic                        rsp_valid,
    input  logic [DATA_W-1:0]           rsp_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_RD_PUSH,
        S_RD_WAIT,
        S_RD_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    // One queued request as seen by the APB-side engine.
    typedef struct packed {
        logic [31:0]        addr;
        logic [DATA_W-1:0]  wdata;
        logic               write;
        logic [NUM_SEL-1:0] sel;
    } req_t;

    state_t             state_q;
    state_t             state_d;

    logic [31:0]        addr_q;
    logic [NUM_SEL-1:0] sel_q;

    req_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LVL_W-1:0]   count_q;
    logic               not_full;
    logic               push;
    logic               pop;
    req_t               push_req;
    req_t               head;

    logic               xfer_active;
    logic               accept;

    logic [31:0]        dec_off;
    logic [31:0]        dec_idx;
    logic               dec_mapped;
    logic [NUM_SEL-1:0] dec_sel;

    // ------------------------------------------------------------------
    // Address decode of the current address phase
    // ------------------------------------------------------------------

    // Decode Haddr into a one-hot select; anything below BASE_ADDR or past the last region is unmapped.
    // NOTE: every variable driven by an always_comb gets a default at the top so no path can infer a latch.
    always_comb begin
        dec_off    = Haddr - BASE_ADDR;
        dec_idx    = dec_off >> REGION_LOG2;
        dec_mapped = (Haddr >= BASE_ADDR) && (dec_idx < NUM_SEL);
        dec_sel    = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            dec_sel[i] = dec_mapped && (dec_idx == 32'(i));
        end
    end

    // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are ignored.
    always_comb begin
        case (Htrans)
            2'b10, 2'b11: xfer_active = 1'b1;
            default:      xfer_active = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus-side outputs: functions of registered state and count only
    // ------------------------------------------------------------------

    assign not_full = (count_q < DEPTH_LVL);

    // Hreadyout/Hresp come from state and the registered FIFO count, never from a bus input.
    always_comb begin
        Hreadyout = 1'b1;
        Hresp     = 1'b0;
        case (state_q)
            S_WR_DATA: Hreadyout = not_full;
            S_RD_PUSH: Hreadyout = 1'b0;
            S_RD_WAIT: Hreadyout = 1'b0;
            S_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = 1'b1;
            end
            S_ERR2:    Hresp     = 1'b1;
            default:   Hreadyout = 1'b1;
        endcase
    end

    assign accept = Hreadyout && Hreadyin && xfer_active;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and FIFO push request; completing states dispatch a newly accepted transfer.
    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_req = '{addr: addr_q, wdata: '0, write: 1'b0, sel: sel_q};

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_WR_DATA: begin
                // When full, hold the data phase until a pop frees a slot.
                if (not_full) begin
                    push     = 1'b1;
                    push_req = '{addr: addr_q, wdata: Hwdata, write: 1'b1, sel: sel_q};
                    state_d  = S_IDLE;
                end
            end
            S_RD_PUSH: begin
                // Reads go through the same FIFO so they stay behind posted writes.
                if (not_full) begin
                    push    = 1'b1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (rsp_valid) begin
                    state_d = S_RD_DONE;
                end
            end
            S_RD_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            S_ERR2: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any edge with Hreadyout high may also start the next transfer.
        if (accept) begin
            if (!dec_mapped) begin
                state_d = S_ERR1;
            end else if (Hwrite) begin
                state_d = S_WR_DATA;
            end else begin
                state_d = S_RD_PUSH;
            end
        end
    end

    // Capture the address-phase information of an accepted transfer for its data phase.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            addr_q <= '0;
            sel_q  <= '0;
        end else if (accept) begin
            addr_q <= Haddr;
            sel_q  <= dec_sel;
        end
    end

    // Read data register; holds its value until the next read response.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Hrdata <= '0;
        end else if ((state_q == S_RD_WAIT) && rsp_valid) begin
            Hrdata <= rsp_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------

    assign pop = req_valid && req_ready;

    // Storage array; contents are qualified by count_q so the entries need no reset.
    // NOTE: only the pointers and the count are reset; the storage is a plain RAM and reset would cost a flop per bit.
    always_ff @(posedge Hclk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_req;
        end
    end

    // Pointers wrap modulo FIFO_DEPTH; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head       = mem[rd_ptr_q];
    assign req_valid  = (count_q != '0);
    assign req_addr   = head.addr;
    assign req_wdata  = head.wdata;
    assign req_write  = head.write;
    assign req_sel    = head.sel;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_ahb_req_pipeline_slave.sv
// Self-checking bench for ahb_req_pipeline_slave.
// A table of single-transfer vectors covers decode, error and ignored-transfer
// cases. Hand-written sequences cover pipelined writes, FIFO-full stall, read
// ordering and response, error back-to-back, and reset mid-operation. Every
// popped request is compared against a scoreboard queue filled as stimulus is driven.
module tb_ahb_req_pipeline_slave;

    localparam int BUDGET = 200;

    logic        Hclk;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic        Hresp;
    logic [31:0] Hrdata;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [2:0]  req_sel;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [2:0]  fifo_level;

    ahb_req_pipeline_slave #(
        .DATA_W      (32),
        .NUM_SEL     (3),
        .FIFO_DEPTH  (4),
        .BASE_ADDR   (32'h8000_0000),
        .REGION_LOG2 (10)
    ) dut (
        .Hclk       (Hclk),
        .Hresetn    (Hresetn),
        .Hwrite     (Hwrite),
        .Hreadyin   (Hreadyin),
        .Htrans     (Htrans),
        .Haddr      (Haddr),
        .Hwdata     (Hwdata),
        .Hreadyout  (Hreadyout),
        .Hresp      (Hresp),
        .Hrdata     (Hrdata),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_write  (req_write),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .fifo_level (fifo_level)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    // Scoreboard entry: what the FIFO head must show when popped.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [2:0]  sel;
    } exp_t;

    // Single-transfer vector: address phase inputs plus expected data-phase responses.
    typedef struct {
        logic [1:0]  trans;
        logic        ready_in;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_push;
        logic [2:0]  exp_sel;
        logic        exp_rdy1;
        logic        exp_rsp1;
        logic        exp_rdy2;
        logic        exp_rsp2;
    } vec_t;

    exp_t        sb [$];
    vec_t        vecs [9];
    int          n_pass;
    int          n_total;
    int          stall_acc;
    int          rsp_cnt;
    logic [31:0] rsp_value;

    logic [31:0] t1_addr [4] = '{32'h8000_0004, 32'h8000_0404, 32'h8000_0808, 32'h8000_0010};
    logic [31:0] t1_data [4] = '{32'hA5A5_5A5A, 32'hAEAE_AEAE, 32'hFEFE_FEFE, 32'hDEAD_DEAD};
    logic [2:0]  t1_sel  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] s);
        exp_t e;
        e.addr  = a;
        e.wdata = d;
        e.write = w;
        e.sel   = s;
        sb.push_back(e);
    endtask

    // Drive one bus beat (address phase of this transfer, data phase of the previous one)
    // and wait, bounded, for the edge that completes it.
    task automatic beat(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        int n;
        Htrans = tr;
        Hwrite = wr;
        Haddr  = a;
        Hwdata = wd;
        n = 0;
        while (Hreadyout !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        if (n == BUDGET) begin
            n_total++;
            $display("FAIL beat_timeout: Hreadyout stuck at %b for %0d cycles, required 1", Hreadyout, n);
        end
        stall_acc += n;
        tick();
    endtask

    // Let the consumer pop until the FIFO is empty, bounded.
    task automatic drain(input string name);
        int n;
        req_ready = 1'b1;
        n = 0;
        while (req_valid === 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        check(name, 32'(fifo_level), 32'd0);
    endtask

    // Consumer-side monitor and read responder, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Hclk);
            if (rsp_cnt == 1) begin
                rsp_valid = 1'b1;
                rsp_rdata = rsp_value;
            end else begin
                rsp_valid = 1'b0;
            end
            if (rsp_cnt > 0) rsp_cnt--;
            if (Hresetn === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected_pop: got addr %h, required no request", req_addr);
                end else begin
                    e = sb.pop_front();
                    check("pop_addr",  req_addr,          e.addr);
                    check("pop_wdata", req_wdata,         e.wdata);
                    check("pop_write", 32'(req_write),    32'(e.write));
                    check("pop_sel",   32'(req_sel),      32'(e.sel));
                    if (req_write === 1'b0) rsp_cnt = 3;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;

        vecs[0] = '{2'b10, 1'b1, 1'b1, 32'h8000_0000, 32'h0101_0101, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2'b11, 1'b1, 1'b1, 32'h8000_07FC, 32'h0202_0202, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{2'b10, 1'b1, 1'b1, 32'h8000_0BFC, 32'h0303_0303, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 1'b1, 1'b1, 32'h8000_0C00, 32'h0404_0404, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{2'b10, 1'b1, 1'b1, 32'h7FFF_FFFC, 32'h0505_0505, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{2'b10, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0606_0606, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{2'b01, 1'b1, 1'b1, 32'h8000_0000, 32'h0707_0707, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{2'b00, 1'b1, 1'b1, 32'h8000_0000, 32'h0808_0808, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{2'b10, 1'b0, 1'b1, 32'h8000_0000, 32'h0909_0909, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};

        n_pass    = 0;
        n_total   = 0;
        stall_acc = 0;
        rsp_cnt   = 0;
        rsp_value = '0;
        Hresetn   = 1'b1;
        Hwrite    = 1'b0;
        Hreadyin  = 1'b1;
        Htrans    = 2'b00;
        Haddr     = '0;
        Hwdata    = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;

        // Reset state
        #2 Hresetn = 1'b0;
        #2;
        check("rst_hreadyout", 32'(Hreadyout),  32'd1);
        check("rst_hresp",     32'(Hresp),      32'd0);
        check("rst_hrdata",    Hrdata,          32'd0);
        check("rst_req_valid", 32'(req_valid),  32'd0);
        check("rst_level",     32'(fifo_level), 32'd0);
        tick();
        tick();
        Hresetn = 1'b1;
        tick();

        // Single-transfer vector table: decode, errors, ignored transfers
        req_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            Htrans   = vecs[i].trans;
            Hreadyin = vecs[i].ready_in;
            Hwrite   = vecs[i].write;
            Haddr    = vecs[i].addr;
            Hwdata   = '0;
            if (vecs[i].exp_push) sb_push(vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].exp_sel);
            tick();
            Htrans   = 2'b00;
            Hreadyin = 1'b1;
            Hwdata   = vecs[i].wdata;
            check($sformatf("vec%0d_rdy1", i), 32'(Hreadyout), 32'(vecs[i].exp_rdy1));
            check($sformatf("vec%0d_rsp1", i), 32'(Hresp),     32'(vecs[i].exp_rsp1));
            tick();
            check($sformatf("vec%0d_rdy2", i), 32'(Hreadyout), 32'(vecs[i].exp_rdy2));
            check($sformatf("vec%0d_rsp2", i), 32'(Hresp),     32'(vecs[i].exp_rsp2));
            tick();
            tick();
            check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'd0);
            check($sformatf("vec%0d_idle_rsp", i), 32'(Hresp), 32'd0);
        end

        // Four pipelined writes, consumer always ready: zero wait states, popped in order
        req_ready = 1'b1;
        stall_acc = 0;
        for (int i = 0; i < 4; i++) begin
            sb_push(t1_addr[i], t1_data[i], 1'b1, t1_sel[i]);
            beat(2'b10, 1'b1, t1_addr[i], (i == 0) ? 32'd0 : t1_data[i-1]);
        end
        beat(2'b00, 1'b0, 32'd0, t1_data[3]);
        check("t1_wait_states", 32'(stall_acc), 32'd0);
        drain("t1_drain");

        // Five writes with consumer stalled: full FIFO stalls the fifth data phase
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb_push(32'h8000_0000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 1'b1, 3'b001);
            beat(2'b10, 1'b1, 32'h8000_0000 + 32'(4 * i), (i == 0) ? 32'd0 : 32'h1111_1111 * 32'(i));
        end
        Htrans = 2'b00;
        Hwrite = 1'b0;
        Hwdata = 32'h5555_5555;
        check("t2_full_level",   32'(fifo_level), 32'd4);
        check("t2_full_stall",   32'(Hreadyout),  32'd0);
        tick();
        tick();
        check("t2_still_stall",  32'(Hreadyout),  32'd0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("t2_ready_rises",  32'(Hreadyout),  32'd1);
        check("t2_level_after_pop", 32'(fifo_level), 32'd3);
        tick();
        check("t2_level_refill", 32'(fifo_level), 32'd4);
        check("t2_idle_ready",   32'(Hreadyout),  32'd1);
        drain("t2_drain");

        // Two posted writes then a read: read popped third, data phase held until response
        req_ready = 1'b1;
        rsp_value = 32'hBEEF_CAFE;
        sb_push(32'h8000_0020, 32'h1357_9BDF, 1'b1, 3'b001);
        sb_push(32'h8000_0824, 32'h2468_ACE0, 1'b1, 3'b100);
        sb_push(32'h8000_0404, 32'h0000_0000, 1'b0, 3'b010);
        beat(2'b10, 1'b1, 32'h8000_0020, 32'd0);
        beat(2'b10, 1'b1, 32'h8000_0824, 32'h1357_9BDF);
        beat(2'b10, 1'b0, 32'h8000_0404, 32'h2468_ACE0);
        Htrans = 2'b00;
        Hwrite = 1'b0;
        Hwdata = '0;
        n = 0;
        while (Hreadyout !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        check("t3_read_stalled", 32'(n > 0),   32'd1);
        check("t3_read_done",    32'(Hreadyout), 32'd1);
        check("t3_hrdata",       Hrdata,       32'hBEEF_CAFE);
        check("t3_hresp",        32'(Hresp),   32'd0);
        tick();
        // A response outside a read wait must not disturb Hrdata
        rsp_value = 32'h1234_5678;
        rsp_cnt   = 1;
        tick();
        tick();
        tick();
        check("t3_stray_rsp",    Hrdata,       32'hBEEF_CAFE);
        check("t3_level",        32'(fifo_level), 32'd0);

        // Unmapped writes back to back with one request queued: level unchanged
        req_ready = 1'b0;
        sb_push(32'h8000_0100, 32'h1111_0000, 1'b1, 3'b001);
        beat(2'b10, 1'b1, 32'h8000_0100, 32'd0);
        beat(2'b10, 1'b1, 32'h8000_0C00, 32'h1111_0000);
        Htrans = 2'b10;
        Haddr  = 32'h7FFF_FFFC;
        Hwdata = '0;
        check("t4_err1_rdy",     32'(Hreadyout),  32'd0);
        check("t4_err1_rsp",     32'(Hresp),      32'd1);
        tick();
        check("t4_err2_rdy",     32'(Hreadyout),  32'd1);
        check("t4_err2_rsp",     32'(Hresp),      32'd1);
        tick();
        Htrans = 2'b00;
        check("t4_b_err1_rdy",   32'(Hreadyout),  32'd0);
        check("t4_b_err1_rsp",   32'(Hresp),      32'd1);
        tick();
        check("t4_b_err2_rdy",   32'(Hreadyout),  32'd1);
        check("t4_b_err2_rsp",   32'(Hresp),      32'd1);
        tick();
        check("t4_idle_rsp",     32'(Hresp),      32'd0);
        check("t4_level",        32'(fifo_level), 32'd1);
        drain("t4_drain");

        // Reset with two writes and a read queued and the read waiting
        req_ready = 1'b0;
        sb_push(32'h8000_0040, 32'hAAAA_0001, 1'b1, 3'b001);
        sb_push(32'h8000_0044, 32'hAAAA_0002, 1'b1, 3'b001);
        sb_push(32'h8000_0048, 32'h0000_0000, 1'b0, 3'b001);
        beat(2'b10, 1'b1, 32'h8000_0040, 32'd0);
        beat(2'b10, 1'b1, 32'h8000_0044, 32'hAAAA_0001);
        beat(2'b10, 1'b0, 32'h8000_0048, 32'hAAAA_0002);
        Htrans = 2'b00;
        Hwrite = 1'b0;
        Hwdata = '0;
        tick();
        check("t6_pre_level",    32'(fifo_level), 32'd3);
        check("t6_pre_wait",     32'(Hreadyout),  32'd0);
        Hresetn = 1'b0;
        #1;
        check("t6_rst_level",    32'(fifo_level), 32'd0);
        check("t6_rst_valid",    32'(req_valid),  32'd0);
        check("t6_rst_ready",    32'(Hreadyout),  32'd1);
        check("t6_rst_hrdata",   Hrdata,          32'd0);
        sb.delete();
        rsp_cnt = 0;
        tick();
        tick();
        Hresetn = 1'b1;
        tick();
        req_ready = 1'b1;
        sb_push(32'h8000_0400, 32'h0C0F_FEE0, 1'b1, 3'b010);
        beat(2'b10, 1'b1, 32'h8000_0400, 32'd0);
        beat(2'b00, 1'b0, 32'd0, 32'h0C0F_FEE0);
        drain("t6_post_drain");
        tick();

        check("sb_all_popped", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
